spi_command_arbiter: RTL and testbench
======================================

# spi_command_arbiter

Round-robin arbiter and sequencer that shares one `slave_command_to_spi` engine between `NUM_REQ` requesters. It accepts 3-bit commands, issues each as a single `transmit` pulse, and routes the returned bytes back tagged with the requester id. It signals completion or error per transaction. It sits between the per-function command sources and the SPI command engine.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 4096: maximum clk cycles spent in WAIT_BUSY or COLLECT before the transaction is aborted.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in NUM_REQ: per-requester request; held high until accepted.
- `req_cmd` in 3*NUM_REQ: command of requester i in bits [3i+2:3i].
- `req_accept` out NUM_REQ: one-cycle one-hot pulse when the request is taken.
- `rsp_valid` out 1: response byte valid, one-cycle pulse.
- `rsp_byte` out 8: response byte.
- `rsp_last` out 1: marks the final expected byte; qualified by `rsp_valid`.
- `rsp_id` out clog2(NUM_REQ): owner of the current transaction; valid with `rsp_valid` and `done`.
- `done` out 1: one-cycle transaction-complete pulse.
- `done_error` out 1: qualified by `done`; 1 means timeout or excess bytes.
- `busy` out 1: high whenever state is not IDLE.
- `spi_ready` in 1: engine idle (`ready`).
- `spi_transmit` out 1: engine `transmit`.
- `spi_command` out 3: engine `command`.
- `spi_tx_byte` in 8: engine received byte.
- `spi_valid_out` in 1: engine byte strobe.

## Operation
- States and transitions:
  - IDLE:
    - Waits until some `req_valid` bit is set and `spi_ready`=1.
    - Grants the first set bit at or after `rr_ptr`, scanning upward with wrap.
    - Latches id and cmd, pulses `req_accept[id]`, sets `rr_ptr` = id+1 mod NUM_REQ, and goes to ISSUE.
  - ISSUE:
    - Drives `spi_transmit`=1 and `spi_command`=cmd for exactly one cycle.
    - Clears the timer and byte counter, then goes to WAIT_BUSY.
  - WAIT_BUSY:
    - On `spi_ready`=0, goes to COLLECT.
    - If `expected_len` is 0 and the timer reaches 2 while `spi_ready` is still 1, treats the command as complete and goes to DONE (error=0).
  - COLLECT:
    - Each `spi_valid_out` produces one registered `rsp_valid` pulse and increments `byte_cnt`.
    - When `spi_ready` returns to 1, goes to DONE.
  - DONE:
    - Pulses `done`.
    - `done_error` = (`byte_cnt` != `expected_len`) or timeout.
    - Returns to IDLE.
  - Timeout: when the timer reaches TIMEOUT_CYCLES in WAIT_BUSY or COLLECT, goes to DONE with error=1. The engine is not reset by this block.
- Response byte handling:
  - `expected_len` = `cmd_rsp_len(cmd)` from the package, range 0..3.
  - `rsp_last`=1 on the byte that makes `byte_cnt` equal `expected_len`.
  - Bytes beyond `expected_len` are dropped (no `rsp_valid`) and force `done_error`.
- Counter widths:
  - `byte_cnt` is 2 bits and saturates at 3.
  - The timer is clog2(TIMEOUT_CYCLES+1) bits and saturates.
- `req_valid` dropping before acceptance is legal: no grant is made and `rr_ptr` is unchanged.
- Simultaneous `spi_valid_out` and `spi_ready` rising: the byte is emitted and DONE follows on the next cycle.

## Timing
- Reset values: every output is 0, state is IDLE, `rr_ptr` = 0.
- Reset mid-transaction:
  - Outputs clear immediately (asynchronous), including `spi_transmit`.
  - No `done` is emitted for the aborted transaction.
- Grant cycle:
  - The cycle after `req_valid` and `spi_ready` are seen in IDLE, `req_accept` is high.
  - `spi_transmit` follows on the next cycle.
- Response latency: `rsp_valid` appears one clk after `spi_valid_out`.
- Completion: `done` appears 2 clk after `spi_ready` rises in COLLECT.
- Back-to-back transactions:
  - The minimum gap from `done` to the next `spi_transmit` is 2 cycles (IDLE, then ISSUE).
  - `req_accept` may coincide with the cycle after `done`.
- All outputs are registered; none is a combinational function of inputs.

## Structure
- Package `spi_cmd_pkg`:
  - `cmd_t` (3-bit) with named command constants.
  - `cmd_rsp_len(cmd_t)` returning 0..3.
  - State enum `arb_state_t`.
- Sub-module `rr_pick`: combinational round-robin selector taking `req_valid` and `rr_ptr`, producing `grant_id` and `grant_any`. Everything else stays in the top module.

## Test plan
- Reset, then requester 2 issues cmd 3 (`expected_len` 1); the engine returns byte 0x55 → `req_accept`=0b0100, one `spi_transmit` with command 3, `rsp_valid` with byte 0x55, `rsp_last`=1, `rsp_id`=2, `done` with error=0.
- All 4 requesters hold `req_valid` continuously → grants are issued in order 0,1,2,3,0; `rr_ptr` wraps correctly.
- The engine returns 2 bytes for a command with `expected_len` 1 → one `rsp_valid` only; `done_error`=1.
- The engine holds `spi_ready`=0 forever with TIMEOUT_CYCLES=16 → `done`, `done_error`=1 exactly 16 cycles after entering WAIT_BUSY; `busy` then falls.
- Assert `rst` in COLLECT mid-byte → all outputs are 0 immediately; no `done`; the next request is granted normally from `rr_ptr`=0.
- Command with `expected_len` 0 where `spi_ready` never drops → `done` with error=0 and no `rsp_valid`.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - command encodings, response lengths and arbiter states
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_NOP         = 3'd0,
        CMD_WRITE_EN    = 3'd1,
        CMD_READ_ID     = 3'd2,
        CMD_READ_STATUS = 3'd3,
        CMD_READ_CFG    = 3'd4,
        CMD_READ_FLAG   = 3'd5,
        CMD_READ_LOCK   = 3'd6,
        CMD_SOFT_RESET  = 3'd7
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_COLLECT,
        ST_DONE
    } arb_state_t;

    // Number of response bytes the engine returns for each command.
    function automatic logic [1:0] cmd_rsp_len(input cmd_t cmd);
        case (cmd)
            CMD_READ_ID:     return 2'd3;
            CMD_READ_STATUS: return 2'd1;
            CMD_READ_CFG:    return 2'd2;
            CMD_READ_FLAG:   return 2'd2;
            CMD_READ_LOCK:   return 2'd1;
            default:         return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector, first request at or after rr_ptr
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [IDW-1:0]     grant_id,
    output logic               grant_any
);

    function automatic int wrap_idx(input int p, input int o);
        int s;
        s = p + o;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // Scan from the farthest offset down so the nearest set bit wins.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req_valid[wrap_idx(int'(rr_ptr), off)]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(wrap_idx(int'(rr_ptr), off));
            end
        end
    end

endmodule

// File: rtl/spi_command_arbiter.sv
// rtl/spi_command_arbiter.sv - shares one SPI command engine between NUM_REQ requesters
module spi_command_arbiter
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int IDW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [3*NUM_REQ-1:0] req_cmd,
    output logic [NUM_REQ-1:0]   req_accept,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_byte,
    output logic                 rsp_last,
    output logic [IDW-1:0]       rsp_id,
    output logic                 done,
    output logic                 done_error,
    output logic                 busy,
    input  logic                 spi_ready,
    output logic                 spi_transmit,
    output logic [2:0]           spi_command,
    input  logic [7:0]           spi_tx_byte,
    input  logic                 spi_valid_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

    arb_state_t        state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    cmd_t              cmd_q, cmd_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              err_q, err_d;
    logic [NUM_REQ-1:0] req_accept_q, req_accept_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_byte_q, rsp_byte_d;
    logic              rsp_last_q, rsp_last_d;
    logic              done_q, done_d;
    logic              done_error_q, done_error_d;
    logic              busy_q;
    logic              spi_transmit_q, spi_transmit_d;
    logic [2:0]        spi_command_q, spi_command_d;

    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [1:0]        exp_len;
    logic [2:0]        cnt_inc;
    logic [TW-1:0]     timer_inc;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign exp_len   = cmd_rsp_len(cmd_q);
    assign cnt_inc   = {1'b0, byte_cnt_q} + 3'd1;
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        id_d           = id_q;
        cmd_d          = cmd_q;
        timer_d        = timer_q;
        byte_cnt_d     = byte_cnt_q;
        err_d          = err_q;
        req_accept_d   = '0;
        rsp_valid_d    = 1'b0;
        rsp_byte_d     = '0;
        rsp_last_d     = 1'b0;
        done_d         = 1'b0;
        done_error_d   = 1'b0;
        spi_transmit_d = 1'b0;
        spi_command_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (grant_any && spi_ready) begin
                    id_d         = grant_id;
                    cmd_d        = cmd_t'(req_cmd[3*int'(grant_id) +: 3]);
                    req_accept_d = NUM_REQ'(1) << grant_id;
                    rr_ptr_d     = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                spi_transmit_d = 1'b1;
                spi_command_d  = cmd_q;
                timer_d        = '0;
                byte_cnt_d     = '0;
                err_d          = 1'b0;
                state_d        = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                timer_d = timer_inc;
                if (timer_inc >= TO_VAL) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (!spi_ready) begin
                    state_d = ST_COLLECT;
                end else if (exp_len == 2'd0 && timer_inc == TW'(2)) begin
                    // Zero-length commands may never visibly drop ready.
                    state_d = ST_DONE;
                end
            end
            ST_COLLECT: begin
                timer_d = timer_inc;
                if (spi_valid_out) begin
                    byte_cnt_d = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
                    if (byte_cnt_q < exp_len) begin
                        rsp_valid_d = 1'b1;
                        rsp_byte_d  = spi_tx_byte;
                        rsp_last_d  = (cnt_inc == {1'b0, exp_len});
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (timer_inc >= TO_VAL) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (spi_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                done_error_d = err_q || (byte_cnt_q != exp_len);
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            id_q           <= '0;
            cmd_q          <= CMD_NOP;
            timer_q        <= '0;
            byte_cnt_q     <= '0;
            err_q          <= 1'b0;
            req_accept_q   <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_byte_q     <= '0;
            rsp_last_q     <= 1'b0;
            done_q         <= 1'b0;
            done_error_q   <= 1'b0;
            busy_q         <= 1'b0;
            spi_transmit_q <= 1'b0;
            spi_command_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            id_q           <= id_d;
            cmd_q          <= cmd_d;
            timer_q        <= timer_d;
            byte_cnt_q     <= byte_cnt_d;
            err_q          <= err_d;
            req_accept_q   <= req_accept_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_byte_q     <= rsp_byte_d;
            rsp_last_q     <= rsp_last_d;
            done_q         <= done_d;
            done_error_q   <= done_error_d;
            busy_q         <= (state_d != ST_IDLE);
            spi_transmit_q <= spi_transmit_d;
            spi_command_q  <= spi_command_d;
        end
    end

    assign req_accept   = req_accept_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_byte     = rsp_byte_q;
    assign rsp_last     = rsp_last_q;
    assign rsp_id       = id_q;
    assign done         = done_q;
    assign done_error   = done_error_q;
    assign busy         = busy_q;
    assign spi_transmit = spi_transmit_q;
    assign spi_command  = spi_command_q;

endmodule

// File: tb/tb_spi_command_arbiter.sv
// tb/tb_spi_command_arbiter.sv - directed self-checking bench for spi_command_arbiter
module tb_spi_command_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [11:0] req_cmd;
    logic [3:0]  req_accept;
    logic        rsp_valid;
    logic [7:0]  rsp_byte;
    logic        rsp_last;
    logic [1:0]  rsp_id;
    logic        done;
    logic        done_error;
    logic        busy;
    logic        spi_ready;
    logic        spi_transmit;
    logic [2:0]  spi_command;
    logic [7:0]  spi_tx_byte;
    logic        spi_valid_out;

    int total = 0;
    int bad   = 0;
    int n;
    int cnt;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    spi_command_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_accept    (req_accept),
        .rsp_valid     (rsp_valid),
        .rsp_byte      (rsp_byte),
        .rsp_last      (rsp_last),
        .rsp_id        (rsp_id),
        .done          (done),
        .done_error    (done_error),
        .busy          (busy),
        .spi_ready     (spi_ready),
        .spi_transmit  (spi_transmit),
        .spi_command   (spi_command),
        .spi_tx_byte   (spi_tx_byte),
        .spi_valid_out (spi_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, req_accept, rsp_valid, rsp_byte, rsp_last, rsp_id,
                done, done_error, busy, spi_transmit, spi_command};
    endfunction

    initial begin
        rst = 1'b1; req_valid = '0; req_cmd = '0;
        spi_ready = 1'b1; spi_tx_byte = '0; spi_valid_out = 1'b0;
        #1;
        chk("reset_async_outs", all_outs(), 0);
        step(); step();
        chk("reset_held_outs", all_outs(), 0);
        rst = 1'b0;
        step();
        chk("idle_outs", all_outs(), 0);

        // Requester 2, READ_STATUS (1 byte), engine returns 0x55
        req_valid = 4'b0100; req_cmd[8:6] = 3'd3;
        step();
        chk("t1_accept", req_accept, 4'b0100);
        chk("t1_busy", busy, 1);
        chk("t1_no_tx_yet", spi_transmit, 0);
        req_valid = '0;
        step();
        chk("t1_transmit", spi_transmit, 1);
        chk("t1_command", spi_command, 3);
        chk("t1_accept_gone", req_accept, 0);
        spi_ready = 1'b0;
        step();
        chk("t1_transmit_one_cycle", spi_transmit, 0);
        spi_valid_out = 1'b1; spi_tx_byte = 8'h55;
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_byte", rsp_byte, 8'h55);
        chk("t1_rsp_last", rsp_last, 1);
        chk("t1_rsp_id", rsp_id, 2);
        spi_valid_out = 1'b0; spi_ready = 1'b1;
        step();
        chk("t1_no_early_done", done, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_done_error", done_error, 0);
        chk("t1_done_id", rsp_id, 2);
        chk("t1_busy_low", busy, 0);
        step();
        chk("t1_done_pulse", done, 0);

        // Requester 3, READ_ID (3 bytes), reset asserted while a byte is arriving
        req_valid = 4'b1000; req_cmd[11:9] = 3'd2;
        step();
        chk("t5_accept", req_accept, 4'b1000);
        req_valid = '0;
        step();
        chk("t5_transmit", spi_transmit, 1);
        spi_ready = 1'b0;
        step();
        spi_valid_out = 1'b1; spi_tx_byte = 8'h3c;
        step();
        chk("t5_rsp_valid", rsp_valid, 1);
        chk("t5_rsp_last", rsp_last, 0);
        rst = 1'b1;
        #1;
        chk("t5_async_clear", all_outs(), 0);
        step(); step();
        rst = 1'b0; spi_valid_out = 1'b0; spi_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || rsp_valid) cnt++;
        end
        chk("t5_no_done_after_rst", cnt, 0);

        // All requesters with zero-length commands; ready never drops
        req_cmd = {3'd0, 3'd7, 3'd1, 3'd0};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_accept == 4'b0 && n < 20) begin
                step();
                n++;
            end
            chk("rr_grant", req_accept, 32'd1 << exp_order[g]);
            if (g > 0) chk("b2b_accept_after_done", n, 1);
            n = 0; cnt = 0;
            while (!done && n < 20) begin
                step();
                n++;
                if (rsp_valid) cnt++;
            end
            if (g == 4) req_valid = '0;
            chk("len0_done_latency", n, 4);
            chk("len0_done_error", done_error, 0);
            chk("len0_no_rsp", cnt, 0);
            chk("len0_id", rsp_id, exp_order[g]);
        end

        // Requester 1, READ_STATUS but engine returns two bytes
        req_valid = 4'b0010; req_cmd[5:3] = 3'd3;
        step();
        chk("t3_accept", req_accept, 4'b0010);
        req_valid = '0;
        step();
        chk("t3_command", spi_command, 3);
        spi_ready = 1'b0;
        step();
        spi_valid_out = 1'b1; spi_tx_byte = 8'haa;
        step();
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_byte", rsp_byte, 8'haa);
        chk("t3_rsp_last", rsp_last, 1);
        spi_tx_byte = 8'hbb;
        step();
        chk("t3_excess_dropped", rsp_valid, 0);
        spi_valid_out = 1'b0; spi_ready = 1'b1;
        step();
        step();
        chk("t3_done", done, 1);
        chk("t3_done_error", done_error, 1);
        chk("t3_done_id", rsp_id, 1);

        // Requester 0 (rr_ptr now 2, wraps), engine never becomes busy-then-ready
        req_valid = 4'b0001; req_cmd[2:0] = 3'd3;
        step();
        chk("t4_accept_wrap", req_accept, 4'b0001);
        req_valid = '0;
        step();
        chk("t4_transmit", spi_transmit, 1);
        spi_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done) cnt++;
        end
        chk("t4_no_early_done", cnt, 0);
        chk("t4_busy_in_done", busy, 1);
        step();
        chk("t4_timeout_done", done, 1);
        chk("t4_timeout_error", done_error, 1);
        chk("t4_busy_falls", busy, 0);
        spi_ready = 1'b1;
        step();
        chk("t4_done_pulse", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
